led_seq_ctrl: RTL

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_pkg.sv | 36 +++
 rtl/led_seq_prescaler.sv | 34 +++
 rtl/led_seq_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: mode encoding, bounce direction
// and the pattern each mode starts from when it is entered.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [3:0] START_BLINK  = 4'b0000;
    localparam logic [3:0] START_COUNT  = 4'b0000;
    localparam logic [3:0] START_CHASE  = 4'b0001;
    localparam logic [3:0] START_BOUNCE = 4'b0001;

    function automatic logic [3:0] start_pattern(input mode_t m);
        case (m)
            MODE_BLINK:  return START_BLINK;
            MODE_COUNT:  return START_COUNT;
            MODE_CHASE:  return START_CHASE;
            default:     return START_BOUNCE;
        endcase
    endfunction

    // BOUNCE wraps back to BLINK through the natural 2-bit overflow.
    function automatic mode_t next_mode(input mode_t m);
        return mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Free-running step prescaler: counts up from INIT and emits a one-cycle
// registered tick each time it passes all-ones.
module led_seq_prescaler #(
    parameter int               PRE_W = 24,
    parameter logic [PRE_W-1:0] INIT  = 24'hfffffa
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic reload,
    output logic tick
);

    logic [PRE_W-1:0] cnt;

    // While disabled the count is frozen and tick is forced low.
    always_ff @(posedge clk) begin
        if (rst || reload) begin
            cnt  <= INIT;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == '1) begin
                cnt  <= INIT;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: btn advances BLINK/COUNT/CHASE/BOUNCE, tick steps the pattern.
// Define LED_SEQ_DEBOUNCE_EN to filter the synchronized btn through a DEB_W-bit debouncer.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int               PRE_W = 24,
    parameter logic [PRE_W-1:0] INIT  = 24'hfffffa,
    parameter int               DEB_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic       pause,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       tick
);

    if (PRE_W < 2 || DEB_W < 1) begin : g_param_check
        $error("led_seq_ctrl: PRE_W must be >= 2 and DEB_W >= 1");
    end

    logic  s1, s2;
    logic  press;
    mode_t mode_q, mode_nx;
    dir_t  dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

`ifdef LED_SEQ_DEBOUNCE_EN
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_level;

    // The accepted level flips only after 2^DEB_W consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt   <= '0;
            deb_level <= 1'b0;
        end else if (s2 != deb_level) begin
            if (deb_cnt == '1) begin
                deb_cnt   <= '0;
                deb_level <= s2;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign press = s2 && !deb_level && (deb_cnt == '1);
`else
    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= s2;
    end

    assign press = s2 && !level_q;
`endif

    led_seq_prescaler #(
        .PRE_W (PRE_W),
        .INIT  (INIT)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (!pause),
        .reload (press),
        .tick   (tick)
    );

    assign mode_nx = next_mode(mode_q);
    assign mode    = mode_q;

    // A press outranks a concurrent tick, so that tick's step is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_BLINK;
            led    <= START_BLINK;
            dir    <= DIR_LEFT;
        end else if (press) begin
            mode_q <= mode_nx;
            led    <= start_pattern(mode_nx);
            dir    <= DIR_LEFT;
        end else if (tick && !pause) begin
            case (mode_q)
                MODE_BLINK: led <= ~led;
                MODE_COUNT: led <= led + 4'd1;
                MODE_CHASE: led <= {led[2:0], led[3]};
                default: begin
                    if (dir == DIR_LEFT) begin
                        if (led == 4'b1000) begin
                            led <= 4'b0100;
                            dir <= DIR_RIGHT;
                        end else begin
                            led <= led << 1;
                        end
                    end else begin
                        if (led == 4'b0001) begin
                            led <= 4'b0010;
                            dir <= DIR_LEFT;
                        end else begin
                            led <= led >> 1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
